// File: rtl/conv_pkg.sv
// Shared definitions for the packed-convolution operand format.
package conv_pkg;

  localparam int unsigned CONV_LANE_W = 5;
  localparam int unsigned CONV_LANES  = 4;
  localparam int unsigned CONV_WORD_W = 32;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_OUT  = 1'b1
  } conv_state_e;

  // Output word payload: packed operand plus end-of-frame flag.
  typedef struct packed {
    logic [CONV_WORD_W-1:0] data;
    logic                   last;
  } conv_word_t;

  // Zero every lane at or above fill; lane k occupies bits [k*lane_w +: lane_w].
  // The ALU-side conv_result unpacker relies on these same lane offsets.
  function automatic logic [CONV_WORD_W-1:0] pack_lanes(
    input logic [CONV_WORD_W-1:0] window,
    input int unsigned            fill,
    input int unsigned            lane_w
  );
    logic [CONV_WORD_W-1:0] word;
    word = '0;
    for (int unsigned b = 0; b < CONV_WORD_W; b++) begin
      if ((b / lane_w) < fill) begin
        word[5'(b)] = window[5'(b)];
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/conv_window_sreg.sv
// Sliding sample window: insert at lane[fill], retain-shift on a full window,
// clear at end of frame.
module conv_window_sreg
  import conv_pkg::*;
#(
  parameter int unsigned LANE_W = CONV_LANE_W,
  parameter int unsigned LANES  = CONV_LANES,
  parameter int unsigned STRIDE = CONV_LANES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           accept_i,
  input  logic [LANE_W-1:0]              data_i,
  input  logic                           last_i,
  output logic [LANES*LANE_W-1:0]        ins_win_c,
  output logic [$clog2(LANES+1)-1:0]     ins_fill_c,
  output logic                           emit_c
);

  localparam int unsigned FILL_W = $clog2(LANES + 1);
  localparam int unsigned KEEP   = LANES - STRIDE;

  logic [LANES-1:0][LANE_W-1:0] win_q;
  logic [LANES-1:0][LANE_W-1:0] win_d;
  logic [LANES-1:0][LANE_W-1:0] ins_win;
  logic [FILL_W-1:0]            fill_q;
  logic [FILL_W-1:0]            fill_d;
  logic                         full_c;

  // Window as seen after the current sample is inserted.
  always_comb begin
    ins_win    = win_q;
    ins_fill_c = fill_q;
    if (accept_i) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (fill_q == FILL_W'(i)) begin
          ins_win[i] = data_i;
        end
      end
      ins_fill_c = fill_q + FILL_W'(1);
    end
  end

  assign ins_win_c = ins_win;
  assign full_c    = (ins_fill_c == FILL_W'(LANES));
  assign emit_c    = accept_i & (last_i | full_c);

  // Next window: clear on frame end, keep the newest LANES-STRIDE on a full window.
  always_comb begin
    win_d  = ins_win;
    fill_d = ins_fill_c;
    if (accept_i && last_i) begin
      win_d  = '0;
      fill_d = '0;
    end else if (accept_i && full_c) begin
      win_d = '0;
      for (int i = 0; i < int'(KEEP); i++) begin
        win_d[i] = ins_win[i + int'(STRIDE)];
      end
      fill_d = FILL_W'(KEEP);
    end
  end

  // Window and fill count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/conv_stream_packer.sv
// Packs a serial LANE_W-bit sample stream into sliding-window 32-bit operand words.
module conv_stream_packer
  import conv_pkg::*;
#(
  parameter int unsigned LANE_W = CONV_LANE_W,
  parameter int unsigned LANES  = CONV_LANES,
  parameter int unsigned STRIDE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANE_W-1:0]      s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CONV_WORD_W-1:0] m_data,
  output logic                   m_last,
  output logic [15:0]            word_cnt
);

  localparam int unsigned FILL_W = $clog2(LANES + 1);
  localparam int unsigned CNT_W  = 16;

  conv_state_e              state_q;
  conv_word_t               word_q;
  conv_word_t               word_d;
  logic                     m_valid_q;
  logic [CNT_W-1:0]         word_cnt_q;

  logic                     accept_c;
  logic                     xfer_c;
  logic                     emit_c;
  logic [LANES*LANE_W-1:0]  ins_win_c;
  logic [FILL_W-1:0]        ins_fill_c;

  // A stalled word blocks new samples, so the window can never overrun.
  assign s_ready  = !m_valid_q | m_ready;
  assign accept_c = s_valid & s_ready;
  assign xfer_c   = m_valid_q & m_ready;

  conv_window_sreg #(
    .LANE_W (LANE_W),
    .LANES  (LANES),
    .STRIDE (STRIDE)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .accept_i   (accept_c),
    .data_i     (s_data),
    .last_i     (s_last),
    .ins_win_c  (ins_win_c),
    .ins_fill_c (ins_fill_c),
    .emit_c     (emit_c)
  );

  // Candidate output word built from the post-insert window.
  always_comb begin
    word_d.data = pack_lanes(CONV_WORD_W'(ins_win_c), 32'(ins_fill_c), LANE_W);
    word_d.last = s_last;
  end

  // Output FSM: load on emit, hold while stalled, reload on transfer+emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FILL;
      m_valid_q  <= 1'b0;
      word_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (emit_c) begin
            word_q    <= word_d;
            m_valid_q <= 1'b1;
            state_q   <= S_OUT;
          end
        end
        S_OUT: begin
          if (xfer_c) begin
            word_cnt_q <= word_q.last ? '0 : word_cnt_q + CNT_W'(1);
            if (emit_c) begin
              word_q <= word_d;
            end else begin
              m_valid_q <= 1'b0;
              state_q   <= S_FILL;
            end
          end
        end
        default: begin
          state_q   <= S_FILL;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = word_q.data;
  assign m_last   = word_q.last;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_conv_stream_packer.sv
// Scoreboard bench for conv_stream_packer with a STRIDE=4 and a STRIDE=1 instance.
module tb_conv_stream_packer;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_last;
  logic [4:0]  a_s_data;
  logic [31:0] a_m_data;
  logic [15:0] a_word_cnt;

  logic        b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last;
  logic [4:0]  b_s_data;
  logic [31:0] b_m_data;
  logic [15:0] b_word_cnt;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          b_xfer_cyc[$];
  int          cnt_a = 0;
  int          cnt_b = 0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_stream_packer #(.LANE_W(5), .LANES(4), .STRIDE(4)) u_s4 (
    .clk(clk), .rst(rst),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last),
    .word_cnt(a_word_cnt)
  );

  conv_stream_packer #(.LANE_W(5), .LANES(4), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .word_cnt(b_word_cnt)
  );

  // Output monitor, STRIDE=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_m_valid && a_m_ready) begin
      n_vec++;
      if (q_a.size() == 0) begin
        n_err++;
        $display("FAIL s4_unexpected_word got=%h", a_m_data);
      end else begin
        e = q_a.pop_front();
        if (a_m_data !== e.data) begin
          n_err++;
          $display("FAIL s4_data got=%h exp=%h", a_m_data, e.data);
        end
        n_vec++;
        if (a_m_last !== e.last) begin
          n_err++;
          $display("FAIL s4_last got=%b exp=%b", a_m_last, e.last);
        end
        n_vec++;
        if (a_word_cnt !== 16'(cnt_a)) begin
          n_err++;
          $display("FAIL s4_word_cnt got=%0d exp=%0d", a_word_cnt, cnt_a);
        end
        n_vec++;
        if (a_m_data[31:20] !== 12'h000) begin
          n_err++;
          $display("FAIL s4_upper_bits got=%h exp=000", a_m_data[31:20]);
        end
        cnt_a = e.last ? 0 : cnt_a + 1;
      end
    end
  end

  // Output monitor, STRIDE=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_m_valid && b_m_ready) begin
      n_vec++;
      b_xfer_cyc.push_back(cyc);
      if (q_b.size() == 0) begin
        n_err++;
        $display("FAIL s1_unexpected_word got=%h", b_m_data);
      end else begin
        e = q_b.pop_front();
        if (b_m_data !== e.data) begin
          n_err++;
          $display("FAIL s1_data got=%h exp=%h", b_m_data, e.data);
        end
        n_vec++;
        if (b_m_last !== e.last) begin
          n_err++;
          $display("FAIL s1_last got=%b exp=%b", b_m_last, e.last);
        end
        n_vec++;
        if (b_word_cnt !== 16'(cnt_b)) begin
          n_err++;
          $display("FAIL s1_word_cnt got=%0d exp=%0d", b_word_cnt, cnt_b);
        end
        cnt_b = e.last ? 0 : cnt_b + 1;
      end
    end
  end

  task automatic push_exp(input int inst, input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    if (inst == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input int inst, input logic [4:0] d, input logic l);
    bit ok = 1'b0;
    if (inst == 0) begin a_s_valid = 1'b1; a_s_data = d; a_s_last = l; end
    else begin b_s_valid = 1'b1; b_s_data = d; b_s_last = l; end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (((inst == 0) ? a_s_ready : b_s_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (inst == 0) a_s_valid = 1'b0;
    else b_s_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout inst=%0d data=%0d", inst, d);
    end
  endtask

  // Wait for the scoreboard to empty, bounded.
  task automatic wait_drain(input int inst);
    int left;
    for (int k = 0; k < 100; k++) begin
      left = (inst == 0) ? q_a.size() : q_b.size();
      if (left == 0) break;
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    left = (inst == 0) ? q_a.size() : q_b.size();
    n_vec++;
    if (left != 0) begin
      n_err++;
      $display("FAIL drain inst=%0d words_missing=%0d exp=0", inst, left);
      if (inst == 0) q_a.delete();
      else q_b.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (a_m_valid !== 1'b0 || b_m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_m_valid got=%b/%b exp=0/0", a_m_valid, b_m_valid);
    end
    n_vec++;
    if (a_m_data !== 32'h0 || a_m_last !== 1'b0 || a_word_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h/%b/%0d exp=0/0/0", a_m_data, a_m_last, a_word_cnt);
    end
    n_vec++;
    if (a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_s_ready got=%b/%b exp=1/1", a_s_ready, b_s_ready);
    end
  endtask

  task automatic test_full_word();
    push_exp(0, 32'h00020C41, 1'b1);
    send(0, 5'd1, 1'b0); send(0, 5'd2, 1'b0); send(0, 5'd3, 1'b0); send(0, 5'd4, 1'b1);
    wait_drain(0);
    n_vec++;
    if (a_word_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL full_word_cnt_clear got=%0d exp=0", a_word_cnt);
    end
  endtask

  task automatic test_partial_word();
    push_exp(0, 32'h00000C41, 1'b1);
    send(0, 5'd1, 1'b0); send(0, 5'd2, 1'b0); send(0, 5'd3, 1'b1);
    wait_drain(0);
  endtask

  task automatic test_multi_word_frame();
    push_exp(0, 32'h00020C41, 1'b0);
    push_exp(0, 32'h000000C5, 1'b1);
    for (int i = 1; i <= 6; i++) send(0, 5'(i), (i == 6));
    wait_drain(0);
  endtask

  task automatic test_back_to_back();
    b_xfer_cyc.delete();
    push_exp(1, 32'h00020C41, 1'b0);
    push_exp(1, 32'h00029062, 1'b1);
    for (int i = 1; i <= 5; i++) send(1, 5'(i), (i == 5));
    wait_drain(1);
    n_vec++;
    if (b_xfer_cyc.size() != 2) begin
      n_err++;
      $display("FAIL b2b_xfer_count got=%0d exp=2", b_xfer_cyc.size());
    end else if (b_xfer_cyc[1] - b_xfer_cyc[0] != 1) begin
      n_err++;
      $display("FAIL b2b_gap got=%0d exp=1", b_xfer_cyc[1] - b_xfer_cyc[0]);
    end
  endtask

  task automatic test_backpressure();
    a_m_ready = 1'b0;
    push_exp(0, 32'h00020C41, 1'b1);
    push_exp(0, 32'h00000005, 1'b1);
    send(0, 5'd1, 1'b0); send(0, 5'd2, 1'b0); send(0, 5'd3, 1'b0); send(0, 5'd4, 1'b1);
    a_s_valid = 1'b1; a_s_data = 5'd5; a_s_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (a_m_valid !== 1'b1 || a_m_data !== 32'h00020C41 || a_m_last !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/00020c41/1", k, a_m_valid, a_m_data, a_m_last);
      end
      n_vec++;
      if (a_s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_s_ready cyc=%0d got=%b exp=0", k, a_s_ready);
      end
      @(posedge clk);
      #1;
    end
    a_m_ready = 1'b1;
    #1;
    n_vec++;
    if (a_s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release_s_ready got=%b exp=1", a_s_ready);
    end
    @(posedge clk);
    #1;
    a_s_valid = 1'b0;
    a_s_last  = 1'b0;
    wait_drain(0);
  endtask

  task automatic test_reset_mid_frame();
    send(0, 5'd9, 1'b0); send(0, 5'd9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    n_vec++;
    if (a_m_valid !== 1'b0 || a_word_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL midreset_out got=%b/%0d exp=0/0", a_m_valid, a_word_cnt);
    end
    n_vec++;
    if (u_s4.u_win.fill_q !== 3'd0) begin
      n_err++;
      $display("FAIL midreset_fill got=%0d exp=0", u_s4.u_win.fill_q);
    end
    push_exp(0, 32'h00039CE7, 1'b1);
    for (int i = 0; i < 4; i++) send(0, 5'd7, (i == 3));
    wait_drain(0);
  endtask

  task automatic test_max_values();
    push_exp(0, 32'h000FFFFF, 1'b1);
    for (int i = 0; i < 4; i++) send(0, 5'd31, (i == 3));
    wait_drain(0);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_word();
    test_multi_word_frame();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_max_values();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
